// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: defaults, blank pattern, state encoding.
package seven_seg_scan_ctrl_pkg;

  localparam int DEF_NUM_DIGITS  = 4;
  localparam int DEF_REFRESH_DIV = 50000;
  localparam int DEF_BLANK_CYC   = 16;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } scan_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seven_seg_hex_dec.sv
// One-digit hex to active-low segment decoder, {a,b,c,d,e,f,g,dp}; dp bit is always off (1).
module seven_seg_hex_dec (
  input  logic [3:0] nibble,
  output logic [7:0] pattern
);

  always_comb begin
    pattern = 8'hFF;
    case (nibble)
      4'h0: pattern = 8'h03;
      4'h1: pattern = 8'h9F;
      4'h2: pattern = 8'h25;
      4'h3: pattern = 8'h0D;
      4'h4: pattern = 8'h99;
      4'h5: pattern = 8'h49;
      4'h6: pattern = 8'h41;
      4'h7: pattern = 8'h1F;
      4'h8: pattern = 8'h01;
      4'h9: pattern = 8'h09;
      4'hA: pattern = 8'h11;
      4'hB: pattern = 8'hC1;
      4'hC: pattern = 8'h63;
      4'hD: pattern = 8'h85;
      4'hE: pattern = 8'h61;
      4'hF: pattern = 8'h71;
      default: pattern = 8'hFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed common-anode display scanner: SHOW/GAP FSM, tear-free shadow loading,
// leading-zero suppression and registered anode/segment outputs.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int BLANK_CYC   = DEF_BLANK_CYC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_sup,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick,
  output logic                    scan_state
);

  localparam int CW = $clog2(max_int(REFRESH_DIV, BLANK_CYC) + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

  scan_state_t             state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           digit_idx;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] active_val;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic                    pending;

  logic [3:0]            nibble;
  logic [7:0]            pattern;
  logic                  dp_cur;
  logic                  lead_zero;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] an_lit;
  logic                  suppress;
  logic                  wrap;
  logic [IW-1:0]         next_idx;

  seven_seg_hex_dec u_dec (
    .nibble  (nibble),
    .pattern (pattern)
  );

  // Walk from the top digit down so zero_run means "this digit and all above it are zero".
  always_comb begin
    nibble    = 4'h0;
    dp_cur    = 1'b0;
    lead_zero = 1'b0;
    an_lit    = '1;
    zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (active_val[4*k +: 4] == 4'h0);
      if (digit_idx == IW'(k)) begin
        nibble    = active_val[4*k +: 4];
        dp_cur    = active_dp[k];
        lead_zero = zero_run;
        an_lit[k] = 1'b0;
      end
    end
  end

  assign suppress   = lz_sup && lead_zero && (digit_idx != '0);
  assign wrap       = en && (state == GAP) && (cnt == GAP_LAST) && (digit_idx == LAST_IDX);
  assign next_idx   = (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
  assign scan_state = state;

  // load is a single-cycle strobe with no back-pressure: it always lands in shadow, and the
  // displayed copy only moves on a frame wrap, so a frame is never drawn from two values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= GAP;
      cnt        <= '0;
      digit_idx  <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      an         <= '1;
      seg        <= SEG_BLANK;
    end else begin
      if (load) begin
        shadow_val <= val_in;
        shadow_dp  <= dp_in;
      end

      if (wrap && pending) begin
        active_val <= shadow_val;
        active_dp  <= shadow_dp;
      end

      if (load) begin
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end

      frame_tick <= wrap;

      if (en) begin
        case (state)
          SHOW: begin
            if (cnt == SHOW_LAST) begin
              state <= GAP;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GAP: begin
            if (cnt == GAP_LAST) begin
              state     <= SHOW;
              cnt       <= '0;
              digit_idx <= next_idx;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end

      // A suppressed digit with its dp set still lights its anode to show the dp alone.
      if (!en || (state == GAP) || (suppress && !dp_cur)) begin
        an  <= '1;
        seg <= SEG_BLANK;
      end else if (suppress) begin
        an  <= an_lit;
        seg <= {SEG_BLANK[7:1], 1'b0};
      end else begin
        an  <= an_lit;
        seg <= {pattern[7:1], pattern[0] & ~dp_cur};
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=2.
module tb_seven_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] val_in;
  logic [3:0]  dp_in;
  logic        lz_sup;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;
  logic        scan_state;

  int n_asserts = 0;
  int n_fail    = 0;

  // Scoreboard entries are {frame_tick, an, seg}.
  logic [12:0] exp_q[$];

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLANK_CYC   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .val_in     (val_in),
    .dp_in      (dp_in),
    .lz_sup     (lz_sup),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick),
    .scan_state (scan_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ft_e, input logic [3:0] an_e,
                           input logic [7:0] seg_e);
    check(tag, {frame_tick, an, seg}, {ft_e, an_e, seg_e});
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    check(tag, {12'h000, frame_tick}, 13'h0001);
  endtask

  // One 24-cycle frame starting right after a frame_tick sample: per digit 4 lit, 2 dark.
  task automatic build_frame(input logic [15:0] an_pk, input logic [31:0] seg_pk);
    int d;
    int ph;
    for (int c = 1; c <= 24; c++) begin
      d  = (c - 1) / 6;
      ph = (c - 1) % 6;
      if (ph < 4) exp_q.push_back({1'b0, an_pk[4*d +: 4], seg_pk[8*d +: 8]});
      else        exp_q.push_back({(c == 24), 4'hF, 8'hFF});
    end
  endtask

  task automatic run_frame(input string tag, input int load_at, input logic [15:0] lv,
                           input logic [3:0] ld);
    logic [12:0] e;
    for (int c = 1; c <= 24; c++) begin
      if (c == load_at) begin
        load   = 1'b1;
        val_in = lv;
        dp_in  = ld;
      end
      step();
      load = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("%s c%0d", tag, c), {frame_tick, an, seg}, e);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    load   = 1'b0;
    val_in = 16'h0000;
    dp_in  = 4'h0;
    lz_sup = 1'b0;
    step();
    step();
    check_out("reset_out", 1'b0, 4'hF, 8'hFF);
    check("reset_state", {12'h000, scan_state}, 13'h0001);

    // Test 1: 1234, no dp, no suppression
    rst_n  = 1'b1;
    en     = 1'b1;
    load   = 1'b1;
    val_in = 16'h1234;
    dp_in  = 4'h0;
    step();
    load = 1'b0;
    wait_tick("t1_first_wrap");
    build_frame(16'h7BDE, 32'h9F250D99);
    run_frame("t1", 10, 16'h00A0, 4'h0);

    // Test 2: 00A0 with leading-zero suppression
    lz_sup = 1'b1;
    build_frame(16'hFFDE, 32'hFFFF1103);
    run_frame("t2", 14, 16'hFFFF, 4'h0);

    // Test 3: FFFF appears only after the wrap; a load on the wrap edge waits a frame
    build_frame(16'h7BDE, 32'h71717171);
    run_frame("t3a", 24, 16'h0000, 4'b0100);
    build_frame(16'h7BDE, 32'h71717171);
    run_frame("t3b", 0, 16'h0000, 4'h0);

    // Test 4: all zero, dp on digit 2 overrides suppression
    build_frame(16'hFBFE, 32'hFFFEFF03);
    run_frame("t4", 0, 16'h0000, 4'h0);

    // Test 5: drop en mid-SHOW of digit 0
    lz_sup = 1'b0;
    step();
    check_out("t5_lit_c1", 1'b0, 4'hE, 8'h03);
    step();
    check_out("t5_lit_c2", 1'b0, 4'hE, 8'h03);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_out($sformatf("t5_dark_%0d", i), 1'b0, 4'hF, 8'hFF);
    end
    en = 1'b1;
    step();
    check_out("t5_resume_c3", 1'b0, 4'hE, 8'h03);
    step();
    check_out("t5_resume_c4", 1'b0, 4'hE, 8'h03);
    step();
    check_out("t5_gap_a", 1'b0, 4'hF, 8'hFF);
    step();
    check_out("t5_gap_b", 1'b0, 4'hF, 8'hFF);
    step();
    check_out("t5_digit1", 1'b0, 4'hD, 8'h03);

    // Test 6: asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check_out("t6_async_out", 1'b0, 4'hF, 8'hFF);
    check("t6_async_state", {12'h000, scan_state}, 13'h0001);
    step();
    check_out("t6_held", 1'b0, 4'hF, 8'hFF);
    rst_n = 1'b1;
    step();
    check_out("t6_gap_a", 1'b0, 4'hF, 8'hFF);
    step();
    check_out("t6_gap_b", 1'b0, 4'hF, 8'hFF);
    step();
    check_out("t6_first_digit1", 1'b0, 4'hD, 8'h03);
    check("t6_show_state", {12'h000, scan_state}, 13'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
